result_bcd_converter: RTL

Sequential binary-to-BCD converter directly downstream of the calculator datapath. It captures the 10-bit quotient (`answer`) and remainder (`residue`) produced by the divider stage and converts both to 4-digit packed BCD using shift-and-add-3 (double-dabble). Both values are converted in parallel, one bit per clock. The BCD outputs feed the seven-segment display driver stage.

---
 rtl/result_bcd_converter.sv | 115 +++++++++++
 1 files changed

// File: rtl/result_bcd_converter.sv
// result_bcd_converter
// Converts the divider's quotient (answer) and remainder (residue) to packed
// BCD for the seven-segment driver. Both values run through shift-and-add-3
// (double-dabble) side by side, one bit per clock, W clocks per conversion.
// The BCD outputs hold the last completed result until the next completion.
module result_bcd_converter #(
   parameter int W      = 10,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [W-1:0]        answer,
   input  logic [W-1:0]        residue,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] ans_bcd,
   output logic [4*DIGITS-1:0] res_bcd
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   ans_bin_q, res_bin_q;
   logic [W-1:0]   ans_bin_d, res_bin_d;
   logic [BW-1:0]  ans_acc_q, res_acc_q;
   logic [BW-1:0]  ans_acc_d, res_acc_d;
   logic [BW-1:0]  ans_adj, res_adj;
   logic [BW-1:0]  ans_bcd_q, res_bcd_q;
   logic           busy_q, done_q;
   logic           last_iter;

   // Add 3 to every digit that is 5 or more, so the following shift carries
   // correctly into the next decimal digit; a digit can therefore never pass 9.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] acc);
      logic [BW-1:0] r;
      r = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // One double-dabble step for both accumulators: adjust, then shift {bcd, bin} left.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      ans_adj   = add3(ans_acc_q);
      res_adj   = add3(res_acc_q);
      ans_acc_d = {ans_adj[BW-2:0], ans_bin_q[W-1]};
      res_acc_d = {res_adj[BW-2:0], res_bin_q[W-1]};
      ans_bin_d = {ans_bin_q[W-2:0], 1'b0};
      res_bin_d = {res_bin_q[W-2:0], 1'b0};
      last_iter = (cnt_q == CW'(W - 1));
   end

   // Control FSM plus datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ans_bin_q <= '0;
         res_bin_q <= '0;
         ans_acc_q <= '0;
         res_acc_q <= '0;
         ans_bcd_q <= '0;
         res_bcd_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  ans_bin_q <= answer;
                  res_bin_q <= residue;
                  ans_acc_q <= '0;
                  res_acc_q <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               ans_acc_q <= ans_acc_d;
               res_acc_q <= res_acc_d;
               ans_bin_q <= ans_bin_d;
               res_bin_q <= res_bin_d;
               cnt_q     <= cnt_q + CW'(1);
               if (last_iter) begin
                  ans_bcd_q <= ans_acc_d;
                  res_bcd_q <= res_acc_d;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign ans_bcd = ans_bcd_q;
   assign res_bcd = res_bcd_q;

endmodule
